// File: rtl/ramarb_pkg.sv
// Shared RAM-side package: arbiter geometry, state encodings and RAM controller constants.
package ramarb_pkg;
  localparam int RA_NREQ   = 3;
  localparam int RA_ADDR_W = 25;
  localparam int RA_LINE_W = 128;

  // RAM controller data port geometry; the arbiter talks to it line-wide with no glue.
  localparam int RAMC_DATA_W     = RA_LINE_W;
  localparam int RAMC_LINE_BYTES = RA_LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    KIND_ACK     = 1'b0,
    KIND_TIMEOUT = 1'b1
  } done_kind_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ramarb_if.sv
// Requester-side and RAM-side bundles for the line arbiter.
interface ramarb_req_if import ramarb_pkg::*; #(
  parameter int NREQ   = RA_NREQ,
  parameter int ADDR_W = RA_ADDR_W,
  parameter int LINE_W = RA_LINE_W
);
  logic [NREQ-1:0]        m_stb;
  logic [NREQ-1:0]        m_we;
  logic [NREQ*ADDR_W-1:0] m_addr;
  logic [NREQ*LINE_W-1:0] m_din;
  logic [LINE_W-1:0]      m_dout;
  logic [NREQ-1:0]        m_ack;
  logic [NREQ-1:0]        m_timeout;

  modport master (output m_stb, m_we, m_addr, m_din, input m_dout, m_ack, m_timeout);
  modport slave  (input m_stb, m_we, m_addr, m_din, output m_dout, m_ack, m_timeout);
endinterface

interface ramarb_ram_if import ramarb_pkg::*; #(
  parameter int ADDR_W = RA_ADDR_W,
  parameter int LINE_W = RA_LINE_W
);
  logic              s_stb;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [LINE_W-1:0] s_din;
  logic [LINE_W-1:0] s_dout;
  logic              s_ack;
  logic              s_timeout;

  modport master (output s_stb, s_we, s_addr, s_din, input s_dout, s_ack, s_timeout);
  modport slave  (input s_stb, s_we, s_addr, s_din, output s_dout, s_ack, s_timeout);
endinterface

// File: rtl/ramarb_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping past NREQ-1.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  int               j;
  logic [IDX_W-1:0] jj;

  // Walk offsets high to low so the lowest offset from ptr is the last writer.
  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IDX_W'(j);
      if (req[jj]) idx = jj;
    end
  end
endmodule

// File: rtl/ramarb.sv
// Round-robin arbiter granting NREQ line requesters one at a time onto a single RAM controller port.
module ramarb import ramarb_pkg::*; #(
  parameter int NREQ   = RA_NREQ,
  parameter int ADDR_W = RA_ADDR_W,
  parameter int LINE_W = RA_LINE_W
) (
  input  logic          clk,
  input  logic          rst,
  ramarb_req_if.slave   m,
  ramarb_ram_if.master  s
);
  localparam int IDX_W = idx_w(NREQ);

  arb_state_t       state, state_nx;
  done_kind_t       kind;
  logic [IDX_W-1:0] ptr, g, pick;
  logic             any;
  logic             we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] din_q, dout_q;
  logic [NREQ-1:0]  ack_v, to_v;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req (m.m_stb),
    .ptr (ptr),
    .any (any),
    .idx (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Timeout wins over ack; DONE never arbitrates so the served requester can drop its strobe.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = BUSY;
      BUSY:    if (s.s_timeout || s.s_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      g      <= '0;
      kind   <= KIND_ACK;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          g      <= pick;
          ptr    <= (pick == IDX_W'(NREQ - 1)) ? '0 : pick + 1'b1;
          we_q   <= m.m_we[pick];
          addr_q <= m.m_addr[pick*ADDR_W +: ADDR_W];
          din_q  <= m.m_din[pick*LINE_W +: LINE_W];
        end
        BUSY: if (s.s_timeout) begin
          kind <= KIND_TIMEOUT;
        end else if (s.s_ack) begin
          kind <= KIND_ACK;
          if (!we_q) dout_q <= s.s_dout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_v = '0;
    to_v  = '0;
    if (state == DONE) begin
      if (kind == KIND_TIMEOUT) to_v[g]  = 1'b1;
      else                      ack_v[g] = 1'b1;
    end
  end

  assign s.s_stb      = (state == BUSY);
  assign s.s_we       = we_q;
  assign s.s_addr     = addr_q;
  assign s.s_din      = din_q;
  assign m.m_dout     = dout_q;
  assign m.m_ack      = ack_v;
  assign m.m_timeout  = to_v;
endmodule

// File: tb/tb_ramarb.sv
// Directed bench for ramarb: reset, round-robin order, read/write data path, timeout, reset abort, fairness.
module tb_ramarb;
  import ramarb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ramarb_req_if #(.NREQ(N), .ADDR_W(AW), .LINE_W(LW)) rq ();
  ramarb_ram_if #(.ADDR_W(AW), .LINE_W(LW)) rm ();

  ramarb #(.NREQ(N), .ADDR_W(AW), .LINE_W(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .m   (rq.slave),
    .s   (rm.master)
  );

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] addr_tab [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_addrs();
    for (int i = 0; i < N; i++) rq.m_addr[i*AW +: AW] = addr_tab[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq.m_stb = '0;
    rq.m_we  = '0;
    rm.s_ack = 1'b0;
    rm.s_timeout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives one RAM-side response; observations are handed back to the caller for checking.
  task automatic txn(input logic ack, input logic to, input logic [LW-1:0] rd,
                     output int g, output logic we, output logic [N-1:0] ack_o,
                     output logic [N-1:0] to_o, output logic [LW-1:0] dout_o);
    bit seen;
    seen = 1'b0;
    g = -1; we = 1'b0; ack_o = '0; to_o = '0; dout_o = '0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      seen = (rm.s_stb === 1'b1);
    end
    if (!seen) return;
    for (int i = 0; i < N; i++) if (rm.s_addr === addr_tab[i]) g = i;
    we = rm.s_we;
    rm.s_ack = ack; rm.s_timeout = to; rm.s_dout = rd;
    tick();
    ack_o = rq.m_ack; to_o = rq.m_timeout; dout_o = rq.m_dout;
    rm.s_ack = 1'b0; rm.s_timeout = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rq.m_stb = 3'b111;
    rq.m_we  = 3'b111;
    rm.s_ack = 1'b1;
    rm.s_timeout = 1'b1;
    tick();
    tick();
    checks++; if (rm.s_stb !== 1'b0) begin failures++; $display("FAIL rst_s_stb got=%0b exp=0", rm.s_stb); end
    checks++; if (rq.m_ack !== 3'b000) begin failures++; $display("FAIL rst_m_ack got=%b exp=000", rq.m_ack); end
    checks++; if (rq.m_timeout !== 3'b000) begin failures++; $display("FAIL rst_m_timeout got=%b exp=000", rq.m_timeout); end
    checks++; if (rm.s_we !== 1'b0) begin failures++; $display("FAIL rst_s_we got=%0b exp=0", rm.s_we); end
    checks++; if (rm.s_addr !== '0) begin failures++; $display("FAIL rst_s_addr got=%h exp=0", rm.s_addr); end
    checks++; if (rm.s_din !== '0) begin failures++; $display("FAIL rst_s_din got=%h exp=0", rm.s_din); end
    checks++; if (rq.m_dout !== '0) begin failures++; $display("FAIL rst_m_dout got=%h exp=0", rq.m_dout); end
    rq.m_stb = '0; rq.m_we = '0; rm.s_ack = 1'b0; rm.s_timeout = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (rm.s_stb !== 1'b0) begin failures++; $display("FAIL rst_idle_s_stb got=%0b exp=0", rm.s_stb); end
  endtask

  task automatic test_rr_order();
    int exp_g [4] = '{0, 1, 2, 0};
    int g; logic we; logic [N-1:0] a, t; logic [LW-1:0] d, rd;
    do_reset();
    addr_tab = '{25'h0000100, 25'h0000101, 25'h0000102};
    load_addrs();
    rq.m_we  = 3'b000;
    rq.m_stb = 3'b111;
    for (int k = 0; k < 4; k++) begin
      rd = {4{32'hC0DE_0000 + 32'(k)}};
      txn(1'b1, 1'b0, rd, g, we, a, t, d);
      checks++; if (g !== exp_g[k]) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, g, exp_g[k]); end
      checks++; if (a !== (N'(1) << exp_g[k])) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, a, N'(1) << exp_g[k]); end
      checks++; if (t !== 3'b000) begin failures++; $display("FAIL rr_to[%0d] got=%b exp=000", k, t); end
      checks++; if (d !== rd) begin failures++; $display("FAIL rr_dout[%0d] got=%h exp=%h", k, d, rd); end
      tick();
      checks++; if (rq.m_ack !== 3'b000) begin failures++; $display("FAIL rr_ack_width[%0d] got=%b exp=000", k, rq.m_ack); end
    end
    rq.m_stb = '0;
    tick();
  endtask

  task automatic test_read_then_write();
    int g; logic we; logic [N-1:0] a, t; logic [LW-1:0] d;
    logic [LW-1:0] rd_val = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    logic [LW-1:0] wr_val = {16{8'hA5}};
    do_reset();
    addr_tab = '{25'h0000200, 25'h0000123, 25'h0000202};
    load_addrs();
    rq.m_we  = 3'b000;
    rq.m_stb = 3'b100;
    txn(1'b1, 1'b0, rd_val, g, we, a, t, d);
    checks++; if (g !== 2) begin failures++; $display("FAIL rd_grant got=%0d exp=2", g); end
    checks++; if (a !== 3'b100) begin failures++; $display("FAIL rd_ack got=%b exp=100", a); end
    checks++; if (d !== rd_val) begin failures++; $display("FAIL rd_dout got=%h exp=%h", d, rd_val); end
    rq.m_stb = '0;
    tick();
    rq.m_din[1*LW +: LW] = wr_val;
    rq.m_we  = 3'b010;
    rq.m_stb = 3'b010;
    tick();
    checks++; if (rm.s_stb !== 1'b1) begin failures++; $display("FAIL wr_s_stb got=%0b exp=1", rm.s_stb); end
    checks++; if (rm.s_we !== 1'b1) begin failures++; $display("FAIL wr_s_we got=%0b exp=1", rm.s_we); end
    checks++; if (rm.s_addr !== 25'h0000123) begin failures++; $display("FAIL wr_s_addr got=%h exp=0000123", rm.s_addr); end
    checks++; if (rm.s_din !== wr_val) begin failures++; $display("FAIL wr_s_din got=%h exp=%h", rm.s_din, wr_val); end
    // Granted requester's inputs change and a bystander raises its strobe mid-transaction.
    rq.m_addr[1*AW +: AW] = 25'h1FF_FFFF;
    rq.m_stb = 3'b011;
    tick();
    checks++; if (rm.s_stb !== 1'b1) begin failures++; $display("FAIL wr_hold_s_stb got=%0b exp=1", rm.s_stb); end
    checks++; if (rm.s_addr !== 25'h0000123) begin failures++; $display("FAIL wr_hold_s_addr got=%h exp=0000123", rm.s_addr); end
    rm.s_ack = 1'b1;
    rm.s_dout = {4{32'hDEAD_BEEF}};
    tick();
    rm.s_ack = 1'b0;
    checks++; if (rq.m_ack !== 3'b010) begin failures++; $display("FAIL wr_ack got=%b exp=010", rq.m_ack); end
    checks++; if (rq.m_dout !== rd_val) begin failures++; $display("FAIL wr_dout_kept got=%h exp=%h", rq.m_dout, rd_val); end
    rq.m_stb = '0;
    tick();
    checks++; if (rq.m_ack !== 3'b000) begin failures++; $display("FAIL wr_ack_width got=%b exp=000", rq.m_ack); end
    checks++; if (rm.s_stb !== 1'b0) begin failures++; $display("FAIL wr_idle_s_stb got=%0b exp=0", rm.s_stb); end
  endtask

  task automatic test_timeout();
    int g; logic we; logic [N-1:0] a, t; logic [LW-1:0] d;
    do_reset();
    addr_tab = '{25'h0000300, 25'h0000301, 25'h0000302};
    load_addrs();
    rq.m_we  = 3'b000;
    rq.m_stb = 3'b001;
    txn(1'b1, 1'b1, {LW{1'b1}}, g, we, a, t, d);
    checks++; if (g !== 0) begin failures++; $display("FAIL to_grant got=%0d exp=0", g); end
    checks++; if (t !== 3'b001) begin failures++; $display("FAIL to_pulse got=%b exp=001", t); end
    checks++; if (a !== 3'b000) begin failures++; $display("FAIL to_ack got=%b exp=000", a); end
    checks++; if (d !== '0) begin failures++; $display("FAIL to_dout got=%h exp=0", d); end
    rq.m_stb = '0;
    tick();
    checks++; if (rq.m_timeout !== 3'b000) begin failures++; $display("FAIL to_width got=%b exp=000", rq.m_timeout); end
  endtask

  task automatic test_reset_in_busy();
    int g; logic we; logic [N-1:0] a, t; logic [LW-1:0] d;
    do_reset();
    addr_tab = '{25'h0000400, 25'h0000401, 25'h0000402};
    load_addrs();
    rq.m_we  = 3'b000;
    rq.m_stb = 3'b010;
    tick();
    checks++; if (rm.s_stb !== 1'b1) begin failures++; $display("FAIL rb_busy got=%0b exp=1", rm.s_stb); end
    rst = 1'b1;
    rm.s_ack = 1'b1;
    tick();
    checks++; if (rm.s_stb !== 1'b0) begin failures++; $display("FAIL rb_s_stb got=%0b exp=0", rm.s_stb); end
    checks++; if (rq.m_ack !== 3'b000) begin failures++; $display("FAIL rb_ack got=%b exp=000", rq.m_ack); end
    rst = 1'b0;
    rm.s_ack = 1'b0;
    rq.m_stb = '0;
    tick();
    checks++; if (rq.m_ack !== 3'b000 || rq.m_timeout !== 3'b000) begin failures++; $display("FAIL rb_no_pulse got=%b/%b exp=000/000", rq.m_ack, rq.m_timeout); end
    // With ptr back at 0, m1 must win over m2.
    rq.m_stb = 3'b110;
    txn(1'b1, 1'b0, {LW{1'b0}}, g, we, a, t, d);
    checks++; if (g !== 1) begin failures++; $display("FAIL rb_regrant got=%0d exp=1", g); end
    checks++; if (a !== 3'b010) begin failures++; $display("FAIL rb_regrant_ack got=%b exp=010", a); end
    rq.m_stb = '0;
    tick();
  endtask

  task automatic test_fairness();
    int g; logic we; logic [N-1:0] a, t; logic [LW-1:0] d;
    do_reset();
    addr_tab = '{25'h0000500, 25'h0000501, 25'h0000502};
    load_addrs();
    rq.m_we  = 3'b000;
    rq.m_stb = 3'b101;
    txn(1'b1, 1'b0, {LW{1'b0}}, g, we, a, t, d);
    checks++; if (g !== 0 || a !== 3'b001) begin failures++; $display("FAIL fair_1 got=%0d/%b exp=0/001", g, a); end
    tick();
    txn(1'b1, 1'b0, {LW{1'b0}}, g, we, a, t, d);
    checks++; if (g !== 2 || a !== 3'b100) begin failures++; $display("FAIL fair_2 got=%0d/%b exp=2/100", g, a); end
    rq.m_stb = 3'b001;
    tick();
    txn(1'b1, 1'b0, {LW{1'b0}}, g, we, a, t, d);
    checks++; if (g !== 0 || a !== 3'b001) begin failures++; $display("FAIL fair_3 got=%0d/%b exp=0/001", g, a); end
    rq.m_stb = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rq.m_stb = '0; rq.m_we = '0; rq.m_addr = '0; rq.m_din = '0;
    rm.s_dout = '0; rm.s_ack = 1'b0; rm.s_timeout = 1'b0;
    test_reset();
    test_rr_order();
    test_read_then_write();
    test_timeout();
    test_reset_in_busy();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
